// File: rtl/ex_mem_stage_if.sv
// EX/MEM boundary bundle: execute-stage inputs, stage controls and memory-stage outputs.
// The master modport drives EX and the stage controls; the slave modport is the pipeline register.
interface ex_mem_stage_if #(
  parameter int WIDTH    = 16,
  parameter int REG_BITS = 4
);
  logic                stall;
  logic                flush;
  logic                ex_valid;
  logic [3:0]          ex_opcode;
  logic [WIDTH-1:0]    ex_alu_result;
  logic                ex_ovfl;
  logic [WIDTH-1:0]    ex_store_data;
  logic [REG_BITS-1:0] ex_rd;
  logic                ex_reg_wr;
  logic                ex_mem_rd;
  logic                ex_mem_wr;
  logic                ex_halt;

  logic                mem_valid;
  logic [3:0]          mem_opcode;
  logic [WIDTH-1:0]    mem_alu_result;
  logic [WIDTH-1:0]    mem_store_data;
  logic [REG_BITS-1:0] mem_rd;
  logic                mem_reg_wr;
  logic                mem_mem_rd;
  logic                mem_mem_wr;
  logic                mem_halt;
  logic [2:0]          flags;
  logic                halted;

  modport master (
    output stall, flush, ex_valid, ex_opcode, ex_alu_result, ex_ovfl, ex_store_data,
           ex_rd, ex_reg_wr, ex_mem_rd, ex_mem_wr, ex_halt,
    input  mem_valid, mem_opcode, mem_alu_result, mem_store_data, mem_rd,
           mem_reg_wr, mem_mem_rd, mem_mem_wr, mem_halt, flags, halted
  );

  modport slave (
    input  stall, flush, ex_valid, ex_opcode, ex_alu_result, ex_ovfl, ex_store_data,
           ex_rd, ex_reg_wr, ex_mem_rd, ex_mem_wr, ex_halt,
    output mem_valid, mem_opcode, mem_alu_result, mem_store_data, mem_rd,
           mem_reg_wr, mem_mem_rd, mem_mem_wr, mem_halt, flags, halted
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register for the WISC core: holds the EX result for MEM, owns the
// {Z,V,N} flag register, and latches a sticky halt once HLT passes through.
module ex_mem_stage #(
  parameter int WIDTH    = 16,
  parameter int REG_BITS = 4
) (
  input  logic           clk,
  input  logic           rst,
  ex_mem_stage_if.slave  bus
);

  typedef enum logic [3:0] {
    OP_ADD    = 4'b0000,
    OP_SUB    = 4'b0001,
    OP_XOR    = 4'b0010,
    OP_RED    = 4'b0011,
    OP_SLL    = 4'b0100,
    OP_SRA    = 4'b0101,
    OP_ROR    = 4'b0110,
    OP_PADDSB = 4'b0111,
    OP_HLT    = 4'b1111
  } opcode_e;

  logic live;
  logic zero;

  // Once halted, everything arriving from EX is squashed into a bubble.
  assign live = bus.ex_valid & ~bus.halted;
  assign zero = (bus.ex_alu_result == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.mem_valid      <= 1'b0;
      bus.mem_opcode     <= '0;
      bus.mem_alu_result <= '0;
      bus.mem_store_data <= '0;
      bus.mem_rd         <= '0;
      bus.mem_reg_wr     <= 1'b0;
      bus.mem_mem_rd     <= 1'b0;
      bus.mem_mem_wr     <= 1'b0;
      bus.mem_halt       <= 1'b0;
      bus.flags          <= 3'b000;
      bus.halted         <= 1'b0;
    end else if (bus.flush) begin
      bus.mem_valid  <= 1'b0;
      bus.mem_reg_wr <= 1'b0;
      bus.mem_mem_rd <= 1'b0;
      bus.mem_mem_wr <= 1'b0;
      bus.mem_halt   <= 1'b0;
    end else if (!bus.stall) begin
      bus.mem_valid      <= live;
      bus.mem_opcode     <= bus.ex_opcode;
      bus.mem_alu_result <= bus.ex_alu_result;
      bus.mem_store_data <= bus.ex_store_data;
      bus.mem_rd         <= bus.ex_rd;
      bus.mem_reg_wr     <= bus.ex_reg_wr & live;
      bus.mem_mem_rd     <= bus.ex_mem_rd & live;
      bus.mem_mem_wr     <= bus.ex_mem_wr & live;
      bus.mem_halt       <= bus.ex_halt & live;
      if (live) begin
        // flags = {Z, V, N}; shift/logic ops touch only Z
        case (opcode_e'(bus.ex_opcode))
          OP_ADD, OP_SUB:
            bus.flags <= {zero, bus.ex_ovfl, bus.ex_alu_result[WIDTH-1]};
          OP_XOR, OP_SLL, OP_SRA, OP_ROR:
            bus.flags[2] <= zero;
          default: ;
        endcase
        if (bus.ex_opcode == OP_HLT) bus.halted <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: a reference model predicts each edge's outputs,
// pushes them to a queue, and the queue is popped and compared one cycle later.
module tb_ex_mem_stage;

  logic clk = 1'b0;
  logic rst;
  int unsigned checks = 0;
  int unsigned errors = 0;

  ex_mem_stage_if #(.WIDTH(16), .REG_BITS(4)) bus ();

  ex_mem_stage #(.WIDTH(16), .REG_BITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [3:0]  op;
    logic [15:0] alu;
    logic [15:0] sd;
    logic [3:0]  rd;
    logic        rw, mr, mw, mh;
    logic [2:0]  flags;
    logic        halted;
    logic        care;
  } exp_t;

  exp_t q[$];

  // reference model state
  logic        m_valid, m_rw, m_mr, m_mw, m_mh, m_halted, m_care;
  logic [3:0]  m_op, m_rd;
  logic [15:0] m_alu, m_sd;
  logic        m_z, m_v, m_n;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_ex(input logic v, input logic [3:0] op, input logic [15:0] alu,
                        input logic ov, input logic [15:0] sd, input logic [3:0] rd,
                        input logic rw, input logic mr, input logic mw, input logic hl);
    bus.ex_valid      = v;
    bus.ex_opcode     = op;
    bus.ex_alu_result = alu;
    bus.ex_ovfl       = ov;
    bus.ex_store_data = sd;
    bus.ex_rd         = rd;
    bus.ex_reg_wr     = rw;
    bus.ex_mem_rd     = mr;
    bus.ex_mem_wr     = mw;
    bus.ex_halt       = hl;
  endtask

  task automatic model_step();
    logic take;
    if (rst) begin
      {m_valid, m_rw, m_mr, m_mw, m_mh, m_halted} = '0;
      m_op = '0; m_rd = '0; m_alu = '0; m_sd = '0;
      {m_z, m_v, m_n} = 3'b000;
      m_care = 1'b1;
    end else if (bus.flush) begin
      {m_valid, m_rw, m_mr, m_mw, m_mh} = '0;
      m_care = 1'b0;
    end else if (!bus.stall) begin
      take    = bus.ex_valid && !m_halted;
      m_op    = bus.ex_opcode;
      m_alu   = bus.ex_alu_result;
      m_sd    = bus.ex_store_data;
      m_rd    = bus.ex_rd;
      m_care  = 1'b1;
      m_valid = take;
      m_rw    = take && bus.ex_reg_wr;
      m_mr    = take && bus.ex_mem_rd;
      m_mw    = take && bus.ex_mem_wr;
      m_mh    = take && bus.ex_halt;
      if (take) begin
        if (bus.ex_opcode == 4'd0 || bus.ex_opcode == 4'd1) begin
          m_z = (bus.ex_alu_result == 16'h0000);
          m_v = bus.ex_ovfl;
          m_n = bus.ex_alu_result[15];
        end else if (bus.ex_opcode == 4'd2 || bus.ex_opcode == 4'd4 ||
                     bus.ex_opcode == 4'd5 || bus.ex_opcode == 4'd6) begin
          m_z = (bus.ex_alu_result == 16'h0000);
        end
        if (bus.ex_opcode == 4'hF) m_halted = 1'b1;
      end
    end
  endtask

  task automatic tick();
    exp_t e;
    model_step();
    e.valid = m_valid; e.op = m_op; e.alu = m_alu; e.sd = m_sd; e.rd = m_rd;
    e.rw = m_rw; e.mr = m_mr; e.mw = m_mw; e.mh = m_mh;
    e.flags = {m_z, m_v, m_n}; e.halted = m_halted; e.care = m_care;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    check("valid",  32'(bus.mem_valid),  32'(e.valid));
    check("reg_wr", 32'(bus.mem_reg_wr), 32'(e.rw));
    check("mem_rd", 32'(bus.mem_mem_rd), 32'(e.mr));
    check("mem_wr", 32'(bus.mem_mem_wr), 32'(e.mw));
    check("halt",   32'(bus.mem_halt),   32'(e.mh));
    check("flags",  32'(bus.flags),      32'(e.flags));
    check("halted", 32'(bus.halted),     32'(e.halted));
    if (e.care) begin
      check("opcode", 32'(bus.mem_opcode),     32'(e.op));
      check("alu",    32'(bus.mem_alu_result), 32'(e.alu));
      check("store",  32'(bus.mem_store_data), 32'(e.sd));
      check("rd",     32'(bus.mem_rd),         32'(e.rd));
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    {m_valid, m_rw, m_mr, m_mw, m_mh, m_halted, m_care} = '0;
    m_op = '0; m_rd = '0; m_alu = '0; m_sd = '0;
    {m_z, m_v, m_n} = 3'b000;

    // reset with a valid ADD presented
    set_ex(1, 4'h0, 16'h1234, 1, 16'h0, 4'd3, 1, 0, 0, 0);
    tick();
    check("rst_valid",  32'(bus.mem_valid), 32'd0);
    check("rst_flags",  32'(bus.flags),     32'd0);
    check("rst_halted", 32'(bus.halted),    32'd0);
    rst = 1'b0;

    // ADD result 0 with overflow -> Z=1 V=1 N=0
    set_ex(1, 4'h0, 16'h0000, 1, 16'h0, 4'd1, 1, 0, 0, 0);
    tick();
    check("add_flags", 32'(bus.flags), 32'b110);
    // XOR 0x8000 -> Z=0, V/N held
    set_ex(1, 4'h2, 16'h8000, 0, 16'h0, 4'd2, 1, 0, 0, 0);
    tick();
    check("xor_flags", 32'(bus.flags), 32'b010);
    // RED passes sign-extended result, no flag effect
    set_ex(1, 4'h3, 16'hFFE2, 0, 16'h0, 4'd4, 1, 0, 0, 0);
    tick();
    check("red_alu",   32'(bus.mem_alu_result), 32'hFFE2);
    check("red_rw",    32'(bus.mem_reg_wr),     32'd1);
    check("red_flags", 32'(bus.flags),          32'b010);

    // stall with changing EX values
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_ex(1, 4'h1, 16'(i), 1, 16'hAAAA, 4'(i), 1, 0, 0, 0);
      tick();
      check("stall_alu",   32'(bus.mem_alu_result), 32'hFFE2);
      check("stall_flags", 32'(bus.flags),          32'b010);
    end
    bus.stall = 1'b0;
    set_ex(1, 4'h1, 16'h8001, 0, 16'h5555, 4'd7, 1, 0, 0, 0);
    tick();
    check("release_alu",   32'(bus.mem_alu_result), 32'h8001);
    check("release_flags", 32'(bus.flags),          32'b001);

    // flush + stall with a valid SW
    bus.stall = 1'b1; bus.flush = 1'b1;
    set_ex(1, 4'h9, 16'h0040, 0, 16'hBEEF, 4'd0, 0, 0, 1, 0);
    tick();
    check("flush_valid", 32'(bus.mem_valid),  32'd0);
    check("flush_wr",    32'(bus.mem_mem_wr), 32'd0);
    check("flush_flags", 32'(bus.flags),      32'b001);
    bus.stall = 1'b0; bus.flush = 1'b0;

    // HLT, then ADD result 0 is squashed
    set_ex(1, 4'hF, 16'h0000, 0, 16'h0, 4'd0, 0, 0, 0, 1);
    tick();
    check("hlt_halt",   32'(bus.mem_halt), 32'd1);
    check("hlt_halted", 32'(bus.halted),   32'd1);
    set_ex(1, 4'h0, 16'h0000, 0, 16'h0, 4'd5, 1, 0, 0, 0);
    tick();
    check("post_hlt_valid", 32'(bus.mem_valid), 32'd0);
    check("post_hlt_flags", 32'(bus.flags),     32'b001);
    rst = 1'b1;
    tick();
    check("rst_clr_halted", 32'(bus.halted), 32'd0);
    rst = 1'b0;

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      rst       = ($urandom_range(0, 39) == 0);
      bus.stall = ($urandom_range(0, 4) == 0);
      bus.flush = ($urandom_range(0, 7) == 0);
      set_ex($urandom_range(0, 3) != 0, op,
             ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom),
             1'($urandom), 16'($urandom), 4'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom), op == 4'hF);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
